// File: rtl/hash_query_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hash_query_ctrl
//  Description : Insert/lookup request sequencer for a 12-bit-addressed hash
//                table. Folds a wide flow key into a table address, issues
//                the query, samples the one-cycle-delayed table response,
//                writes successful inserts and returns one result per request.
//  Revision    : 1.0 - initial release
// ============================================================================

package hash_query_pkg;
    typedef enum logic {
        INSERT_QUERY  = 1'b0,
        LOOK_UP_QUERY = 1'b1
    } hash_query_t;
endpackage

module hash_query_ctrl
    import hash_query_pkg::*;
#(
    parameter int KEY_W    = 12,
    parameter int VAL_W    = 32,
    parameter int IN_KEY_W = 48,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  hash_query_t         req_op_i,
    input  logic [IN_KEY_W-1:0] req_key_i,
    input  logic [VAL_W-1:0]    req_val_i,
    output logic                wr_en_o,
    output hash_query_t         hash_query_o,
    output logic [KEY_W-1:0]    hash_wr_key_o,
    output logic [KEY_W-1:0]    hash_rd_key_o,
    output logic [VAL_W-1:0]    hash_insert_val_o,
    output logic [VAL_W-1:0]    hash_lookup_val_o,
    input  logic                table_resp_i,
    output logic                res_valid_o,
    input  logic                res_ready_i,
    output hash_query_t         res_op_o,
    output logic                res_hit_o,
    output logic                res_err_o,
    output logic [CNT_W-1:0]    ins_fail_cnt_o
);

    localparam int c_num_chunks = (IN_KEY_W + KEY_W - 1) / KEY_W;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_QUERY = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t                         r_state;
    state_t                         w_next_state;
    logic [c_num_chunks*KEY_W-1:0]  w_padded_key;
    logic [KEY_W-1:0]               w_hash;
    logic                           w_accept;
    logic                           w_val_zero;

    hash_query_t                    r_op;
    logic [KEY_W-1:0]               r_hash;
    logic [VAL_W-1:0]               r_val;
    hash_query_t                    r_res_op;
    logic                           r_res_hit;
    logic                           r_res_err;
    logic [CNT_W-1:0]               r_ins_fail_cnt;

    assign w_accept   = req_valid_i && (r_state == S_IDLE);
    assign w_val_zero = (req_val_i == '0);

    // Zero-pad the key to a whole number of chunks and XOR-fold it to an address
    always_comb begin
        w_padded_key                 = '0;
        w_padded_key[IN_KEY_W-1:0]   = req_key_i;
        w_hash                       = '0;
        for (int i = 0; i < c_num_chunks; i++) begin
            w_hash = w_hash ^ w_padded_key[i*KEY_W +: KEY_W];
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: zero values skip the table, only empty-slot inserts write
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (req_valid_i) w_next_state = w_val_zero ? S_RESP : S_QUERY;
            S_QUERY: w_next_state = S_WAIT;
            S_WAIT:  w_next_state = ((r_op == INSERT_QUERY) && table_resp_i) ? S_WRITE : S_RESP;
            S_WRITE: w_next_state = S_RESP;
            S_RESP:  if (res_ready_i) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Request/result registers and the saturating failed-insert counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op           <= INSERT_QUERY;
            r_hash         <= '0;
            r_val          <= '0;
            r_res_op       <= INSERT_QUERY;
            r_res_hit      <= 1'b0;
            r_res_err      <= 1'b0;
            r_ins_fail_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_res_op  <= req_op_i;
                r_res_hit <= 1'b0;
                r_res_err <= w_val_zero;
                // Table-facing registers only move for requests that reach the table
                if (!w_val_zero) begin
                    r_op   <= req_op_i;
                    r_hash <= w_hash;
                    r_val  <= req_val_i;
                end
            end
            if (r_state == S_WAIT) begin
                r_res_hit <= table_resp_i;
                if ((r_op == INSERT_QUERY) && !table_resp_i && (r_ins_fail_cnt != '1)) begin
                    r_ins_fail_cnt <= r_ins_fail_cnt + 1'b1;
                end
            end
        end
    end

    assign req_ready_o       = (r_state == S_IDLE);
    assign wr_en_o           = (r_state == S_WRITE);
    assign res_valid_o       = (r_state == S_RESP);
    assign hash_query_o      = r_op;
    assign hash_rd_key_o     = r_hash;
    assign hash_wr_key_o     = r_hash;
    assign hash_insert_val_o = r_val;
    assign hash_lookup_val_o = r_val;
    assign res_op_o          = r_res_op;
    assign res_hit_o         = r_res_hit;
    assign res_err_o         = r_res_err;
    assign ins_fail_cnt_o    = r_ins_fail_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hash_query_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hash_query_ctrl
//  Description : Scoreboard bench for hash_query_ctrl with a table model and
//                a behavioural reference of insert/lookup semantics.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hash_query_ctrl;
    import hash_query_pkg::*;

    localparam int KEY_W    = 12;
    localparam int VAL_W    = 32;
    localparam int IN_KEY_W = 48;
    localparam int CNT_W    = 6;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                req_valid_i = 1'b0;
    logic                req_ready_o;
    hash_query_t         req_op_i = INSERT_QUERY;
    logic [IN_KEY_W-1:0] req_key_i = '0;
    logic [VAL_W-1:0]    req_val_i = '0;
    logic                wr_en_o;
    hash_query_t         hash_query_o;
    logic [KEY_W-1:0]    hash_wr_key_o;
    logic [KEY_W-1:0]    hash_rd_key_o;
    logic [VAL_W-1:0]    hash_insert_val_o;
    logic [VAL_W-1:0]    hash_lookup_val_o;
    logic                table_resp_i = 1'b0;
    logic                res_valid_o;
    logic                res_ready_i = 1'b0;
    hash_query_t         res_op_o;
    logic                res_hit_o;
    logic                res_err_o;
    logic [CNT_W-1:0]    ins_fail_cnt_o;

    hash_query_ctrl #(
        .KEY_W(KEY_W), .VAL_W(VAL_W), .IN_KEY_W(IN_KEY_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_key_i(req_key_i), .req_val_i(req_val_i),
        .wr_en_o(wr_en_o), .hash_query_o(hash_query_o), .hash_wr_key_o(hash_wr_key_o),
        .hash_rd_key_o(hash_rd_key_o), .hash_insert_val_o(hash_insert_val_o),
        .hash_lookup_val_o(hash_lookup_val_o), .table_resp_i(table_resp_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_op_o(res_op_o),
        .res_hit_o(res_hit_o), .res_err_o(res_err_o), .ins_fail_cnt_o(ins_fail_cnt_o)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int errors  = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Address = XOR of every key bit into bit position (i mod KEY_W)
    function automatic logic [KEY_W-1:0] ref_hash(input logic [IN_KEY_W-1:0] k);
        logic [KEY_W-1:0] h = '0;
        for (int i = 0; i < IN_KEY_W; i++) h[i % KEY_W] = h[i % KEY_W] ^ k[i];
        return h;
    endfunction

    typedef struct {
        hash_query_t      op;
        logic             hit;
        logic             err;
        logic [CNT_W-1:0] cnt;
        int unsigned      acc;
        int unsigned      lat;
        logic             exp_wr;
        logic [KEY_W-1:0] key;
        logic [VAL_W-1:0] val;
        int unsigned      wr_before;
    } exp_t;

    exp_t             sb[$];
    logic [VAL_W-1:0] ref_mem [0:4095];
    logic [VAL_W-1:0] tbl     [0:4095];
    logic [CNT_W-1:0] exp_cnt = '0;
    int unsigned      wr_total = 0;
    int unsigned      last_wr_cyc = 0;
    logic [KEY_W-1:0] last_wr_key = '0;
    logic [VAL_W-1:0] last_wr_val = '0;
    int unsigned      last_hs = 0;
    bit               have_hs = 0;
    bit               in_resp = 0;

    // Table model: registered response from the previous cycle's query, writes applied on wr_en
    initial begin
        logic pending;
        pending = 1'b0;
        for (int i = 0; i < 4096; i++) begin tbl[i] = '0; ref_mem[i] = '0; end
        forever begin
            @(negedge clk);
            table_resp_i = pending;
            if (wr_en_o) begin
                tbl[hash_wr_key_o] = hash_insert_val_o;
                wr_total++;
                last_wr_cyc = cyc;
                last_wr_key = hash_wr_key_o;
                last_wr_val = hash_insert_val_o;
            end
            pending = (hash_query_o == INSERT_QUERY) ? (tbl[hash_rd_key_o] == '0)
                                                     : (tbl[hash_rd_key_o] == hash_lookup_val_o);
        end
    end

    // Monitor: pop and compare on each new result, check stability while held, randomize ready
    initial begin
        exp_t e;
        int   hold = 0;
        int   waitc = 0;
        forever begin
            @(negedge clk);
            if (rst && res_valid_o) begin
                waitc = 0;
                if (!in_resp) begin
                    if (sb.size() == 0) begin
                        check("unexpected_result", 1, 0);
                        e.op = res_op_o; e.hit = res_hit_o; e.err = res_err_o; e.cnt = ins_fail_cnt_o;
                        e.key = hash_rd_key_o;
                    end else begin
                        e = sb.pop_front();
                        check("res_op", res_op_o, e.op);
                        check("res_hit", res_hit_o, e.hit);
                        check("res_err", res_err_o, e.err);
                        check("fail_cnt", ins_fail_cnt_o, e.cnt);
                        check("latency", cyc - e.acc, e.lat);
                        check("write_count", wr_total - e.wr_before, e.exp_wr);
                        if (e.exp_wr) begin
                            check("write_cycle", last_wr_cyc, e.acc + 3);
                            check("write_key", last_wr_key, e.key);
                            check("write_data", last_wr_val, e.val);
                        end
                    end
                    in_resp = 1;
                    hold = ($urandom_range(0, 7) == 0) ? 10 : $urandom_range(0, 2);
                end else begin
                    check("hold_op", res_op_o, e.op);
                    check("hold_hit", res_hit_o, e.hit);
                    check("hold_err", res_err_o, e.err);
                    check("hold_cnt", ins_fail_cnt_o, e.cnt);
                    if (!e.err) check("hold_rd_key", hash_rd_key_o, e.key);
                    check("hold_wr_en", wr_en_o, 0);
                end
                check("ready_during_resp", req_ready_o, 0);
                if (hold == 0) begin
                    res_ready_i = 1'b1;
                    in_resp = 0;
                    last_hs = cyc;
                    have_hs = 1;
                end else begin
                    res_ready_i = 1'b0;
                    hold--;
                end
            end else begin
                res_ready_i = $urandom_range(0, 1);
                if (sb.size() > 0) begin
                    waitc++;
                    if (waitc > 20) begin
                        check("result_timeout", 0, 1);
                        void'(sb.pop_front());
                        waitc = 0;
                    end
                end else begin
                    waitc = 0;
                end
            end
        end
    end

    task automatic send(input hash_query_t op, input logic [IN_KEY_W-1:0] key, input logic [VAL_W-1:0] val);
        exp_t             e;
        int unsigned      start;
        int               n;
        logic [KEY_W-1:0] h;
        @(negedge clk);
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_key_i   = key;
        req_val_i   = val;
        start = cyc;
        n = 0;
        while (!req_ready_o && n < 200) begin @(negedge clk); n++; end
        if (!req_ready_o) begin
            check("accept_timeout", 0, 1);
            req_valid_i = 1'b0;
            return;
        end
        h = ref_hash(key);
        e.op = op; e.acc = cyc; e.key = h; e.val = val; e.wr_before = wr_total;
        e.exp_wr = 1'b0; e.err = 1'b0; e.hit = 1'b0; e.lat = 3;
        if (val == '0) begin
            e.err = 1'b1;
            e.lat = 1;
        end else if (op == INSERT_QUERY) begin
            e.hit = (ref_mem[h] == '0);
            if (e.hit) begin
                ref_mem[h] = val;
                e.exp_wr   = 1'b1;
                e.lat      = 4;
            end else if (exp_cnt != '1) begin
                exp_cnt = exp_cnt + 1'b1;
            end
        end else begin
            e.hit = (ref_mem[h] == val);
        end
        e.cnt = exp_cnt;
        if (have_hs && start <= last_hs) check("turnaround", cyc, last_hs + 1);
        sb.push_back(e);
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        if (val != '0) begin
            @(negedge clk);
            check("query_rd_key", hash_rd_key_o, h);
            check("query_type", hash_query_o, op);
            check("query_lookup_val", hash_lookup_val_o, val);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"}, req_ready_o, 1);
        check({tag, "_res_valid"}, res_valid_o, 0);
        check({tag, "_wr_en"}, wr_en_o, 0);
        check({tag, "_cnt"}, ins_fail_cnt_o, 0);
        check({tag, "_rd_key"}, hash_rd_key_o, 0);
        check({tag, "_query"}, hash_query_o, INSERT_QUERY);
        check({tag, "_ins_val"}, hash_insert_val_o, 0);
        check({tag, "_res_hit"}, res_hit_o, 0);
    endtask

    // Main stimulus: reset, directed cases, saturation, random traffic, reset mid-insert
    initial begin
        logic [IN_KEY_W-1:0] pool [0:5];
        logic [IN_KEY_W-1:0] k;
        logic [VAL_W-1:0]    v;
        hash_query_t         op;
        int unsigned         wb;
        int                  n;

        repeat (3) @(negedge clk);
        check_reset_values("in_reset");
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("after_reset");

        send(INSERT_QUERY, 48'h123456789ABC, 32'hDEAD0001);
        send(INSERT_QUERY, 48'h123456789ABC, 32'hDEAD0001);
        send(INSERT_QUERY, 48'h000000000001, 32'd5);
        send(LOOK_UP_QUERY, 48'h000000000001, 32'd5);
        send(LOOK_UP_QUERY, 48'h000000000001, 32'd6);
        send(INSERT_QUERY, 48'h00000000BEEF, 32'd0);
        send(LOOK_UP_QUERY, 48'h123456789ABC, 32'd0);
        send(LOOK_UP_QUERY, 48'h123456789ABC, 32'hDEAD0001);

        repeat (70) send(INSERT_QUERY, 48'h123456789ABC, 32'h1);

        for (int i = 0; i < 6; i++) pool[i] = {$urandom(), $urandom()};
        pool[1] = pool[0] ^ 48'h000001001;
        for (int i = 0; i < 300; i++) begin
            op = hash_query_t'($urandom_range(0, 1));
            k  = ($urandom_range(0, 3) == 0) ? {$urandom(), $urandom()} : pool[$urandom_range(0, 5)];
            n  = $urandom_range(0, 9);
            if (n == 0)      v = '0;
            else if (n < 5)  v = (op == LOOK_UP_QUERY) ? ref_mem[ref_hash(k)] : $urandom_range(1, 3);
            else begin       v = $urandom(); if (v == '0) v = 1; end
            send(op, k, v);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        n = 0;
        while ((sb.size() != 0 || in_resp || res_valid_o) && n < 200) begin @(negedge clk); n++; end
        check("drain", sb.size(), 0);

        k = '0;
        while (ref_mem[ref_hash(k)] != '0 && k < 4095) k = k + 1'b1;
        @(negedge clk);
        req_valid_i = 1'b1; req_op_i = INSERT_QUERY; req_key_i = k; req_val_i = 32'hCAFE;
        n = 0;
        while (!req_ready_o && n < 50) begin @(negedge clk); n++; end
        check("rst_test_accept", req_ready_o, 1);
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        wb = wr_total;
        rst = 1'b0;
        #1;
        check_reset_values("mid_reset");
        repeat (3) begin
            @(negedge clk);
            check("mid_reset_no_write", wr_en_o, 0);
        end
        rst = 1'b1;
        exp_cnt = '0;
        repeat (3) begin
            @(negedge clk);
            check("post_reset_no_result", res_valid_o, 0);
            check("post_reset_ready", req_ready_o, 1);
        end
        check("reset_write_suppressed", wr_total - wb, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
